// File: rtl/instr_fetch.sv
// Instruction fetch front end. It drives the byte address to a 16-bit
// instruction memory with a one-cycle registered read, tracks the single
// read in flight, and buffers the returned halfwords in a small FIFO. Decode
// reads the FIFO head over a valid/ready handshake. A redirect flushes all
// fetch state. A fetch beyond the end of memory is delivered as a fault and
// then parks the unit in HALT until the next redirect.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned DEPTH     = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] pc_o,
  input  logic [15:0] pc_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [15:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_fault_o,
  output logic        halted_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(DEPTH);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t         state_q;
  logic [31:0]    pc_q;
  logic           inflight_q;
  logic [31:0]    inflight_pc_q;
  logic [PW-1:0]  rd_ptr_q;
  logic [PW-1:0]  wr_ptr_q;
  logic [CW-1:0]  count_q;

  logic [15:0]    buf_instr [DEPTH];
  logic [31:0]    buf_pc    [DEPTH];
  logic           buf_fault [DEPTH];

  logic           pop;
  logic           push;
  logic           issue;
  logic           capture_fault;
  logic [CW-1:0]  count_after_pop;
  logic [CW:0]    need;
  logic [31:0]    redirect_pc;

  // Handshake, capture and flush qualifiers shared by the sequential blocks.
  assign instr_valid_o   = (count_q != '0);
  assign pop             = instr_valid_o & instr_ready_i;
  assign push            = inflight_q & ~redirect_i;
  assign count_after_pop = count_q - CW'(pop);
  assign capture_fault   = (inflight_pc_q >= MEM_LIMIT);
  assign redirect_pc     = redirect_pc_i & ~32'h1;

  // Issue a new fetch only when the buffer can hold it together with the
  // read already in flight, counting the slot freed by this cycle's pop.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    issue = 1'b0;
    need  = {1'b0, count_after_pop} + (CW + 1)'(inflight_q) + (CW + 1)'(1);
    if (state_q == RUN && !redirect_i && need <= DEPTH_LIM) begin
      issue = 1'b1;
    end
  end

  // Fetch control: PC, in-flight tracking, FIFO pointers and the RUN/HALT FSM.
  // A redirect overrides every other update in the same cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
    end else if (redirect_i) begin
      state_q    <= RUN;
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= pc_q;
        pc_q          <= pc_q + 32'd2;
        if (pc_q >= MEM_LIMIT) begin
          state_q <= HALT;
        end
      end
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage: capture the returned halfword with its PC and fault tag.
  // NOTE: the storage array has no reset; count_q gates every read, so stale
  // contents are never observed and the array can map to plain flops/RAM.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_instr[wr_ptr_q] <= capture_fault ? 16'h0 : pc_data_i;
      buf_pc[wr_ptr_q]    <= inflight_pc_q;
      buf_fault[wr_ptr_q] <= capture_fault;
    end
  end

  // Head outputs read zero while the buffer is empty.
  assign pc_o          = pc_q;
  assign instr_o       = instr_valid_o ? buf_instr[rd_ptr_q] : 16'h0;
  assign instr_pc_o    = instr_valid_o ? buf_pc[rd_ptr_q]    : 32'h0;
  assign instr_fault_o = instr_valid_o ? buf_fault[rd_ptr_q] : 1'b0;
  assign halted_o      = (state_q == HALT);

  // A capture must always find a free slot once this cycle's pop is applied.
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      push |-> (count_after_pop < DEPTH_LIM[CW-1:0])
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch. The driver pushes the expected delivery
// stream (PC, halfword, fault) whenever fetch (re)starts; a negedge monitor
// pops and compares on every handshake.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic [15:0] pc_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        halted;

  typedef struct {
    logic [31:0] pc;
    logic [15:0] data;
    logic        fault;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [1024];
  int         checks = 0;
  int         errors = 0;

  instr_fetch #(.RESET_PC(RESET_PC), .MEM_BYTES(1024), .DEPTH(2)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pc_o          (pc),
    .pc_data_i     (pc_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_fault_o (instr_fault),
    .halted_o      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instruction memory; out-of-range reads return junk.
  always @(posedge clk) begin
    if (pc < 32'd1024) pc_data <= {mem[pc[9:0] | 10'd1], mem[pc[9:0]]};
    else               pc_data <= 16'hDEAD;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] p);
    exp_t e;
    e.pc    = p;
    e.fault = (p >= 32'd1024);
    e.data  = e.fault ? 16'h0 : {mem[p[9:0] | 10'd1], mem[p[9:0]]};
    return e;
  endfunction

  // Replace the expected stream with a fresh sequential run from start.
  task automatic expect_from(input logic [31:0] start);
    logic [31:0] p;
    exp_t        e;
    exp_q.delete();
    p = start & ~32'h1;
    for (int i = 0; i < 256; i++) begin
      e = model(p);
      exp_q.push_back(e);
      if (e.fault) break;
      p = p + 32'd2;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    @(posedge clk);
    #1;
    redirect = 1'b0;
    expect_from(target);
  endtask

  // Monitor: every accepted instruction must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %0h with no instruction expected at %0t", instr_pc, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("instr_pc", 64'(instr_pc), 64'(e.pc));
        check("instr_data", 64'(instr), 64'(e.data));
        check("instr_fault", 64'(instr_fault), 64'(e.fault));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc_hold;
    logic [31:0] head_hold;

    for (int i = 0; i < 1024; i++) mem[i] = 8'(i * 37 + 11);
    mem[0] = 8'h01; mem[1] = 8'h23; mem[2] = 8'h45; mem[3] = 8'h67;
    mem[4] = 8'h89; mem[5] = 8'hAB; mem[6] = 8'hCD; mem[7] = 8'hEF;

    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    #2;
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_pc", 64'(pc), 64'(RESET_PC));
    check("rst_instr", 64'(instr), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
    check("rst_fault", 64'(instr_fault), 64'd0);
    check("rst_halted", 64'(halted), 64'd0);

    // 1. Stream from reset: first valid two edges after release
    expect_from(RESET_PC);
    #10 rst_n = 1'b1;
    tick(1);
    check("t1_lat_valid0", 64'(instr_valid), 64'd0);
    tick(1);
    check("t1_first_valid", 64'(instr_valid), 64'd1);
    check("t1_first_instr", 64'(instr), 64'h2301);
    check("t1_first_pc", 64'(instr_pc), 64'h0);
    tick(1);
    check("t1_second_instr", 64'(instr), 64'h6745);
    check("t1_second_pc", 64'(instr_pc), 64'h2);
    tick(1);
    check("t1_third_instr", 64'(instr), 64'hAB89);
    check("t1_third_pc", 64'(instr_pc), 64'h4);
    tick(4);

    // 2. Stall decode for 5 cycles: fetch stops, head holds
    instr_ready = 1'b0;
    tick(2);
    pc_hold   = pc;
    head_hold = instr_pc;
    tick(3);
    check("t2_pc_stalled", 64'(pc), 64'(pc_hold));
    check("t2_head_stable", 64'(instr_pc), 64'(head_hold));
    check("t2_valid_held", 64'(instr_valid), 64'd1);
    instr_ready = 1'b1;
    tick(8);

    // 3. Redirect to an odd address while the buffer fills
    instr_ready = 1'b0;
    tick(1);
    do_redirect(32'h41);
    instr_ready = 1'b1;
    check("t3_pc_aligned", 64'(pc), 64'h40);
    tick(1);
    check("t3_flushed", 64'(instr_valid), 64'd0);
    tick(1);
    check("t3_valid", 64'(instr_valid), 64'd1);
    check("t3_first_pc", 64'(instr_pc), 64'h40);
    tick(4);

    // Back-to-back redirects: last one wins
    do_redirect(32'h100);
    do_redirect(32'h200);
    tick(1);
    check("b2b_flushed", 64'(instr_valid), 64'd0);
    tick(1);
    check("b2b_first_pc", 64'(instr_pc), 64'h200);
    tick(4);

    // 4. Run off the end of memory: fault delivered, then HALT
    do_redirect(32'd1016);
    tick(12);
    check("t4_halted", 64'(halted), 64'd1);
    check("t4_no_valid", 64'(instr_valid), 64'd0);
    check("t4_pc_parked", 64'(pc), 64'd1026);
    check("t4_all_delivered", 64'(exp_q.size()), 64'd0);
    do_redirect(32'h0);
    check("t4_resumed", 64'(halted), 64'd0);
    tick(2);
    check("t4_resume_pc", 64'(instr_pc), 64'h0);
    tick(5);

    // 5. Half-cycle reset pulse mid-stream
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_valid", 64'(instr_valid), 64'd0);
    check("t5_async_pc", 64'(pc), 64'(RESET_PC));
    expect_from(RESET_PC);
    #1 rst_n = 1'b1;
    tick(1);
    check("t5_lat_valid0", 64'(instr_valid), 64'd0);
    tick(1);
    check("t5_restart_pc", 64'(instr_pc), 64'(RESET_PC));
    check("t5_restart_instr", 64'(instr), 64'h2301);
    tick(5);

    // 6. Random ready and random redirects against the scoreboard
    for (int i = 0; i < 500; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        do_redirect(32'($urandom_range(0, 1100)) & ~32'h1);
      end else begin
        tick(1);
      end
    end

    // Drain cleanly
    instr_ready = 1'b1;
    do_redirect(32'd1000);
    tick(20);
    check("final_drained", 64'(exp_q.size()), 64'd0);
    check("final_halted", 64'(halted), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
